// File: rtl/txn_resp_collect.sv
// Warp response collector: forwards tagged line requests to memory, tracks the
// lanes each tag serves, and scatters returning line words into per-lane results.

module txn_resp_lane #(
    parameter int OFF_W     = 4,
    parameter int WORD_BITS = 32,
    parameter int LINE_BITS = 512
) (
    input  logic                 clr,
    input  logic                 wr,
    input  logic [OFF_W-1:0]     off,
    input  logic [LINE_BITS-1:0] line,
    input  logic [WORD_BITS-1:0] cur,
    output logic [WORD_BITS-1:0] nxt
);
    localparam int WORDS = LINE_BITS / WORD_BITS;

    logic [WORDS-1:0][WORD_BITS-1:0] words;

    assign words = line;

    always_comb begin
        nxt = cur;
        if (clr)
            nxt = '0;
        else if (wr)
            nxt = words[off];
    end
endmodule

module txn_resp_collect #(
    parameter int W          = 32,
    parameter int ADDR_W     = 64,
    parameter int LINE_SHIFT = 6,
    parameter int WORD_SHIFT = 2,
    parameter int MAX_OUT    = 8,
    parameter int TAG_W      = $clog2(MAX_OUT),
    parameter int OFF_W      = LINE_SHIFT - WORD_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      warp_start,
    output logic                      warp_start_ready,
    input  logic [W-1:0]              warp_lane_valid,
    input  logic [W*OFF_W-1:0]        warp_lane_offs_flat,
    input  logic                      in_req_valid,
    output logic                      in_req_ready,
    input  logic [ADDR_W-1:0]         in_req_addr,
    input  logic [W-1:0]              in_req_lane_mask,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [TAG_W-1:0]          mem_req_tag,
    input  logic                      rsp_valid,
    output logic                      rsp_ready,
    input  logic [TAG_W-1:0]          rsp_tag,
    input  logic [(8<<LINE_SHIFT)-1:0] rsp_data,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [W*32-1:0]           done_data_flat,
    output logic                      tag_err
);
    localparam int WORD_BITS = 8 << WORD_SHIFT;
    localparam int LINE_BITS = 8 << LINE_SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [MAX_OUT-1:0]                  valid_q, valid_d;
    logic [MAX_OUT-1:0][W-1:0]           mask_q, mask_d;
    logic [W-1:0]                        pending_q, pending_d;
    logic [W-1:0][OFF_W-1:0]             offs_q, offs_d;
    logic [W-1:0][WORD_BITS-1:0]         data_q, data_d;
    logic                                tag_err_q, tag_err_d;

    logic               active;
    logic               full;
    logic [TAG_W-1:0]   free_tag;
    logic               start_hs;
    logic               req_hs;
    logic               rsp_hs;
    logic               rsp_hit;
    logic [W-1:0]       lane_wr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (warp_start)       state_d = S_ACTIVE;
            S_ACTIVE: if (pending_q == '0)  state_d = S_DONE;
            S_DONE:   if (done_ready)       state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Output logic; full looks only at registered valids so a same-cycle free
    // cannot be re-allocated before it has actually cleared.
    always_comb begin
        active           = (state_q == S_ACTIVE);
        full             = &valid_q;
        warp_start_ready = (state_q == S_IDLE);
        done_valid       = (state_q == S_DONE);
        mem_req_valid    = active & in_req_valid & ~full;
        in_req_ready     = active & mem_req_ready & ~full;
        rsp_ready        = active;
        mem_req_addr     = in_req_addr;
        mem_req_tag      = free_tag;
        done_data_flat   = data_q;
        tag_err          = tag_err_q;
    end

    // Lowest-index free tag: scan high to low so the last hit wins.
    always_comb begin
        free_tag = '0;
        for (int t = MAX_OUT - 1; t >= 0; t--)
            if (!valid_q[t])
                free_tag = TAG_W'(t);
    end

    assign start_hs = warp_start & (state_q == S_IDLE);
    assign req_hs   = in_req_valid & in_req_ready;
    assign rsp_hs   = rsp_valid & rsp_ready;
    assign rsp_hit  = rsp_hs & valid_q[rsp_tag];
    assign lane_wr  = rsp_hit ? mask_q[rsp_tag] : '0;

    generate
        for (genvar g = 0; g < W; g++) begin : g_lane
            txn_resp_lane #(
                .OFF_W     (OFF_W),
                .WORD_BITS (WORD_BITS),
                .LINE_BITS (LINE_BITS)
            ) u_lane (
                .clr  (start_hs),
                .wr   (lane_wr[g]),
                .off  (offs_q[g]),
                .line (rsp_data),
                .cur  (data_q[g]),
                .nxt  (data_d[g])
            );
        end
    endgenerate

    // Tag tracker and warp bookkeeping
    always_comb begin
        valid_d   = valid_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        offs_d    = offs_q;
        tag_err_d = tag_err_q;

        if (start_hs) begin
            pending_d = warp_lane_valid;
            offs_d    = warp_lane_offs_flat;
        end

        if (req_hs) begin
            valid_d[free_tag] = 1'b1;
            mask_d[free_tag]  = in_req_lane_mask;
        end

        // Allocated and freed tags always differ: one was free, the other valid.
        if (rsp_hit) begin
            pending_d        = pending_q & ~mask_q[rsp_tag];
            valid_d[rsp_tag] = 1'b0;
        end else if (rsp_hs) begin
            tag_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            offs_q    <= '0;
            data_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            offs_q    <= offs_d;
            data_q    <= data_d;
            tag_err_q <= tag_err_d;
        end
    end
endmodule

// File: doc/txn_resp_collect.md
Name: txn_resp_collect

Overview:
- Sits between the warp transaction-formation unit and the memory request channel.
- Forwards line requests to memory, tagging each one.
- Tracks which lanes each outstanding tag serves.
- On each line response, scatters the per-lane words into a warp result buffer and signals completion once every active lane has been filled.

Parameters:
W, 32, warp width (lanes)
ADDR_W, 64, address width
LINE_SHIFT, 6, log2 line bytes (64B lines)
WORD_SHIFT, 2, log2 lane word bytes (32-bit words)
MAX_OUT, 8, outstanding transactions (power of two); TAG_W = clog2(MAX_OUT), OFF_W = LINE_SHIFT-WORD_SHIFT

Ports:
clk  in  1  clock
rst_n  in  1  reset
warp_start  in  1  begin a warp
warp_start_ready  out  1  high only in IDLE
warp_lane_valid  in  W  active lanes
warp_lane_offs_flat  in  W*OFF_W  per-lane word offset within its line
in_req_valid  in  1  request from transaction formation
in_req_ready  out  1  request accepted
in_req_addr  in  ADDR_W  line-aligned address
in_req_lane_mask  in  W  lanes served by the request
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts
mem_req_addr  out  ADDR_W  forwarded in_req_addr
mem_req_tag  out  TAG_W  allocated tag
rsp_valid  in  1  line response
rsp_ready  out  1  response accepted
rsp_tag  in  TAG_W  tag of response
rsp_data  in  8<<LINE_SHIFT  line data; word k = bits [32k+31:32k]
done_valid  out  1  warp results ready
done_ready  in  1  consumer takes results
done_data_flat  out  W*32  lane results, lane i at [32i+31:32i]
tag_err  out  1  sticky: response arrived with an unallocated tag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state: state=IDLE; all tag valid bits 0; pending=0; offsets=0; done_data_flat=0; done_valid=0; tag_err=0.
  - warp_start_ready is 1 after reset. mem_req_valid, in_req_ready and rsp_ready are all 0.
  - Reset mid-operation discards every outstanding tag and any partial results.
- States:
  - IDLE: warp_start=1 latches lane_valid into pending, latches the offsets, clears done_data_flat, and moves to ACTIVE.
  - ACTIVE: runs forwarding and collection. When pending==0 (registered), go to DONE on the next edge.
  - DONE: done_valid=1 and done_data_flat holds steady. On done_ready, go to IDLE.
- A warp with lane_valid==0 passes IDLE -> ACTIVE -> DONE, reaching done_valid two cycles after warp_start.
- Request forwarding (combinational pass-through, ACTIVE only):
  - full = all tag valid bits set (registered).
  - mem_req_valid = in_req_valid & ~full. in_req_ready = mem_req_ready & ~full.
  - mem_req_tag = lowest-index free tag.
  - On handshake: set valid[tag] and store mask[tag]=in_req_lane_mask.
  - A tag freed in the same cycle is not visible to the full calculation until the next cycle.
- Response collection:
  - rsp_ready=1 in ACTIVE; 0 in IDLE and DONE.
  - On handshake with valid[rsp_tag]=1: for every lane i in mask[rsp_tag], write done_data_flat lane i <= word offs[i] of rsp_data. Then pending &= ~mask[rsp_tag] and valid[rsp_tag] <= 0.
  - Results are visible one cycle after the handshake, so done_valid is asserted no earlier than 2 cycles after the last response.
  - Response to an unallocated tag: no data write, no state change, tag_err<=1. tag_err holds until reset.
  - Lanes in a mask that are not in pending are still written; that is not an error.
  - Allocation and free of different tags in the same cycle both take effect.
- One response is processed per cycle. Requests arriving in IDLE or DONE are stalled (in_req_ready=0).

Test Plan:
- Unit-stride warp, all 32 lanes: two requests (0x1000 mask 0x0000FFFF, 0x1040 mask 0xFFFF0000) get tags 0 and 1. Responses in order 1, 0 with line words = lane index -> done_data lane i = i; done_valid 2 cycles after the last response.
- Broadcast: lane_valid=0xF, all offsets 3, one request mask 0xF, response word3=0xDEADBEEF -> all four lanes read 0xDEADBEEF.
- Full tracker: 8 requests accepted with tags 0..7. A 9th request sees in_req_ready=0 and mem_req_valid=0. A response to tag 5 frees it, and the next request gets tag 5 one cycle later.
- Backpressure: mem_req_ready=0 for 3 cycles -> no tag allocated and in_req_ready=0; the request goes through on the cycle ready rises.
- Bad tag: response with tag 6 while only tag 0 is valid -> tag_err=1, done_data unchanged, pending unchanged.
- Edge cases: lane_valid=0 gives done_valid 2 cycles after start. rst_n=0 with 3 tags outstanding clears everything; after reset, the first request gets tag 0.
